pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program counter stage that sits directly upstream of instruction memory.
//  The PC register is a bank of DFFs clocked on clk and cleared by an asynchronous reset.
//  Presents fetch addresses to memory over a valid/ready handshake.
//  Supports sequential increment, jump redirect (deferred if a fetch is pending),
//  halt, and end-of-program detection.
// PARAMETERS
//  ADDR_W     8     PC / address width in bits (word-addressed)
//  RESET_ADDR 0     PC value loaded by reset
//  LAST_ADDR  255   last valid program address
//  WRAP       0     1: PC wraps LAST_ADDR->0; 0: halt after fetching LAST_ADDR
//  CNT_W      16    width of the fetch counter
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous reset, active-high
//  start        in   1       leave IDLE and begin fetching
//  halt_req     in   1       request stop; honoured at next handshake or immediately if no fetch pending
//  jump_valid   in   1       one-cycle jump request
//  jump_addr    in   ADDR_W  jump target
//  mem_ready    in   1       memory accepts the current address
//  pc_addr      out  ADDR_W  current fetch address (registered)
//  addr_valid   out  1       pc_addr is a live fetch request
//  halted       out  1       block is in HALT
//  fetch_count  out  CNT_W   completed handshakes, saturating
// BEHAVIOUR
//  Reset (async, any time):
//   - pc_addr=RESET_ADDR, addr_valid=0, halted=0, fetch_count=0
//   - pending jump cleared, state=IDLE
//   - A fetch in flight is abandoned; no handshake is counted.
//  States: IDLE, FETCH, HALT. All outputs are registered.
//  IDLE:
//   - addr_valid=0.
//   - start=1: FETCH next cycle, addr_valid=1, pc_addr unchanged.
//   - jump_valid in IDLE loads pc_addr=jump_addr directly.
//   - halt_req in IDLE: HALT.
//  FETCH:
//   - addr_valid=1; pc_addr held stable until handshake (addr_valid&mem_ready).
//   - Handshake cycle, next pc priority: jump_valid this cycle > pending jump > pc+1.
//   - pc+1 is modulo 2^ADDR_W; at pc==LAST_ADDR:
//     - WRAP=1: next pc=0.
//     - WRAP=0: go to HALT, pc_addr holds LAST_ADDR.
//   - jump_valid without handshake: target latched as pending (later request overwrites);
//     pc_addr does not change.
//   - fetch_count += 1 per handshake, saturating at all-ones.
//   - halt_req (level or pulse) sets a halt flag.
//     - Next handshake goes to HALT; pc_addr still advances per priority.
//     - halt_req and handshake in the same cycle: HALT next cycle.
//  HALT:
//   - addr_valid=0, halted=1; start, jump, and mem_ready are ignored. Exit only via reset.
//  Latency: one handshake per cycle max; the new pc_addr is visible the cycle after the handshake.
// TESTING
//  1. reset pulse 1 cycle, start=1, mem_ready=1 for 4 cycles
//     -> pc_addr 0,1,2,3,4; fetch_count=4.
//  2. mem_ready=0 for 3 cycles at pc=5, jump_valid pulse to 0x40 in cycle 2
//     -> pc_addr stays 5; after ready, pc_addr=0x40.
//  3. jump_valid=0x20 and handshake in the same cycle at pc=7
//     -> next pc_addr=0x20, not 8; count+1.
//  4. LAST_ADDR=3, WRAP=0, ready always
//     -> fetches 0..3, then halted=1, addr_valid=0, pc_addr=3.
//  5. Same with WRAP=1
//     -> pc_addr sequence 2,3,0,1; never halts.
//  6. reset asserted mid-FETCH, off clock edge
//     -> outputs clear immediately; after reset, IDLE with addr_valid=0 until start.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program counter stage in front of instruction memory. Presents word
// addresses over a valid/ready handshake and supports:
// - sequential increment
// - jump redirect (held as pending while a fetch is outstanding)
// - halt
// - end-of-program detection
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active-high
//   start        in   leave IDLE and begin fetching
//   halt_req     in   request stop (taken at next handshake, or at once in IDLE)
//   jump_valid   in   one-cycle jump request
//   jump_addr    in   jump target
//   mem_ready    in   memory accepts pc_addr this cycle
//   pc_addr      out  current fetch address (registered)
//   addr_valid   out  pc_addr is a live fetch request
//   halted       out  block is in HALT (left only through reset)
//   fetch_count  out  completed handshakes, saturating at all-ones
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int RESET_ADDR = 0,
    parameter int LAST_ADDR  = 255,
    parameter bit WRAP       = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              addr_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_ZERO  = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [ADDR_W-1:0] pend_addr_nxt_s;
    logic              pend_valid_r;
    logic              pend_valid_nxt_s;
    logic              halt_flag_r;
    logic              halt_flag_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              addr_valid_r;
    logic              halted_r;
    logic              handshake_s;
    logic              end_halt_s;

    assign handshake_s = addr_valid_r & mem_ready;
    // Falling off the end only stops us when nothing redirects the PC.
    assign end_halt_s  = (pc_r == LAST_PC) & ~WRAP & ~jump_valid & ~pend_valid_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (halt_req) begin
                    next_state_s = ST_HALT;
                end else if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (handshake_s && (halt_flag_r || halt_req || end_halt_s)) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next PC, pending jump, halt flag and counter values.
    always_comb begin
        pc_nxt_s         = pc_r;
        pend_addr_nxt_s  = pend_addr_r;
        pend_valid_nxt_s = pend_valid_r;
        halt_flag_nxt_s  = halt_flag_r;
        cnt_nxt_s        = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (jump_valid) begin
                    pc_nxt_s = jump_addr;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_FETCH: begin
                if (handshake_s) begin
                    pend_valid_nxt_s = 1'b0;
                    if (cnt_r == CNT_MAX) begin
                        cnt_nxt_s = cnt_r;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                    // A jump arriving with the handshake beats an older pending one.
                    if (jump_valid) begin
                        pc_nxt_s = jump_addr;
                    end else if (pend_valid_r) begin
                        pc_nxt_s = pend_addr_r;
                    end else if (pc_r == LAST_PC) begin
                        if (WRAP) begin
                            pc_nxt_s = PC_ZERO;
                        end else begin
                            pc_nxt_s = pc_r;
                        end
                    end else begin
                        pc_nxt_s = pc_r + PC_ONE;
                    end
                end else begin
                    // Address must stay stable while memory stalls; park the jump.
                    if (jump_valid) begin
                        pend_valid_nxt_s = 1'b1;
                        pend_addr_nxt_s  = jump_addr;
                    end else begin
                        pend_valid_nxt_s = pend_valid_r;
                    end
                    if (halt_req) begin
                        halt_flag_nxt_s = 1'b1;
                    end else begin
                        halt_flag_nxt_s = halt_flag_r;
                    end
                end
            end
            ST_HALT: pc_nxt_s = pc_r;
            default: pc_nxt_s = pc_r;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            pend_addr_r  <= PC_ZERO;
            pend_valid_r <= 1'b0;
            halt_flag_r  <= 1'b0;
            cnt_r        <= CNT_ZERO;
            addr_valid_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            pend_addr_r  <= pend_addr_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            halt_flag_r  <= halt_flag_nxt_s;
            cnt_r        <= cnt_nxt_s;
            addr_valid_r <= (next_state_s == ST_FETCH);
            halted_r     <= (next_state_s == ST_HALT);
        end
    end

    assign pc_addr     = pc_r;
    assign addr_valid  = addr_valid_r;
    assign halted      = halted_r;
    assign fetch_count = cnt_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit.
// Three instances share the same stimulus:
//   u0: defaults
//   u1: LAST_ADDR=3, WRAP=0
//   u2: LAST_ADDR=3, WRAP=1, 3-bit counter
// A per-instance behavioural model predicts every output.
module tb_pc_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       halt_req;
    logic       jump_valid;
    logic [7:0] jump_addr;
    logic       mem_ready;

    logic [7:0]  pc0, pc1, pc2;
    logic        av0, av1, av2;
    logic        hl0, hl1, hl2;
    logic [15:0] c0, c1;
    logic [2:0]  c2;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HALT  = 2;

    int last_a [3] = '{255, 3, 3};
    bit wrap_a [3] = '{1'b0, 1'b0, 1'b1};
    int cmax_a [3] = '{65535, 65535, 7};

    int m_mode      [3];
    int m_pc        [3];
    int m_cnt       [3];
    bit m_pend      [3];
    int m_pend_addr [3];
    bit m_hflag     [3];

    always #5 clk = ~clk;

    pc_fetch_unit u0 (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .jump_valid(jump_valid), .jump_addr(jump_addr), .mem_ready(mem_ready),
        .pc_addr(pc0), .addr_valid(av0), .halted(hl0), .fetch_count(c0)
    );

    pc_fetch_unit #(.LAST_ADDR(3), .WRAP(1'b0)) u1 (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .jump_valid(jump_valid), .jump_addr(jump_addr), .mem_ready(mem_ready),
        .pc_addr(pc1), .addr_valid(av1), .halted(hl1), .fetch_count(c1)
    );

    pc_fetch_unit #(.LAST_ADDR(3), .WRAP(1'b1), .CNT_W(3)) u2 (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .jump_valid(jump_valid), .jump_addr(jump_addr), .mem_ready(mem_ready),
        .pc_addr(pc2), .addr_valid(av2), .halted(hl2), .fetch_count(c2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_mode[k]      = M_IDLE;
            m_pc[k]        = 0;
            m_cnt[k]       = 0;
            m_pend[k]      = 1'b0;
            m_pend_addr[k] = 0;
            m_hflag[k]     = 1'b0;
        end
    endtask

    // One clock of the reference behaviour, using the inputs held across the edge.
    task automatic model_step(input int k);
        bit stop;
        stop = 1'b0;
        case (m_mode[k])
            M_IDLE: begin
                if (jump_valid) m_pc[k] = jump_addr;
                if (halt_req) m_mode[k] = M_HALT;
                else if (start) m_mode[k] = M_FETCH;
            end
            M_FETCH: begin
                if (mem_ready) begin
                    stop = m_hflag[k] || halt_req;
                    if (m_cnt[k] < cmax_a[k]) m_cnt[k] = m_cnt[k] + 1;
                    if (jump_valid) m_pc[k] = jump_addr;
                    else if (m_pend[k]) m_pc[k] = m_pend_addr[k];
                    else if (m_pc[k] == last_a[k]) begin
                        if (wrap_a[k]) m_pc[k] = 0;
                        else stop = 1'b1;
                    end else m_pc[k] = (m_pc[k] + 1) % 256;
                    m_pend[k] = 1'b0;
                    if (stop) m_mode[k] = M_HALT;
                end else begin
                    if (jump_valid) begin
                        m_pend[k]      = 1'b1;
                        m_pend_addr[k] = jump_addr;
                    end
                    if (halt_req) m_hflag[k] = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            logic [7:0]  pc;
            logic        av;
            logic        hl;
            logic [15:0] cnt;
            case (k)
                0: begin pc = pc0; av = av0; hl = hl0; cnt = c0; end
                1: begin pc = pc1; av = av1; hl = hl1; cnt = c1; end
                default: begin pc = pc2; av = av2; hl = hl2; cnt = {13'd0, c2}; end
            endcase
            check_eq($sformatf("u%0d_pc", k), pc, m_pc[k]);
            check_eq($sformatf("u%0d_valid", k), av, (m_mode[k] == M_FETCH));
            check_eq($sformatf("u%0d_halted", k), hl, (m_mode[k] == M_HALT));
            check_eq($sformatf("u%0d_count", k), cnt, m_cnt[k]);
        end
    endtask

    task automatic step(input bit st, input bit hr, input bit jv, input logic [7:0] ja, input bit rdy);
        start      = st;
        halt_req   = hr;
        jump_valid = jv;
        jump_addr  = ja;
        mem_ready  = rdy;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        compare_all();
    endtask

    // Reset raised between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_pc_now", pc0, 8'h00);
        check_eq("rst_valid_now", av0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; jump_valid = 1'b0;
        jump_addr = 8'h00; mem_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        check_eq("reset_pc", pc0, 8'h00);
        check_eq("reset_count", c0, 16'd0);
        reset = 1'b0;

        // Sequential fetch; the LAST_ADDR=3 instances see end of program / wrap.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("start_valid", av0, 1'b1);
        check_eq("start_pc", pc0, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            check_eq("seq_pc", pc0, i);
            if (i == 3) check_eq("wrap_pc3", pc2, 8'd3);
        end
        check_eq("seq_count", c0, 16'd4);
        check_eq("end_halted", hl1, 1'b1);
        check_eq("end_valid", av1, 1'b0);
        check_eq("end_pc", pc1, 8'd3);
        check_eq("wrap_pc0", pc2, 8'd0);

        // Stall at pc=5 with a jump arriving mid-stall.
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("wrap_pc1", pc2, 8'd1);
        check_eq("wrap_not_halted", hl2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_eq("stall_pc_a", pc0, 8'd5);
        step(1'b0, 1'b0, 1'b1, 8'h40, 1'b0);
        check_eq("stall_pc_b", pc0, 8'd5);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_eq("stall_pc_c", pc0, 8'd5);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("pend_jump_pc", pc0, 8'h40);

        // Jump coincident with handshake.
        step(1'b0, 1'b0, 1'b1, 8'h07, 1'b1);
        check_eq("jump_to7", pc0, 8'h07);
        step(1'b0, 1'b0, 1'b1, 8'h20, 1'b1);
        check_eq("hs_jump_pc", pc0, 8'h20);
        check_eq("hs_jump_count", c0, 16'd8);
        check_eq("count_sat", c2, 3'd7);

        // Halt request during a stall is remembered until the next handshake.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check_eq("hflag_still_valid", av0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_eq("hflag_still_fetch", hl0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("halt_pc", pc0, 8'h21);
        check_eq("halt_halted", hl0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        check_eq("halt_ignores_jump", pc0, 8'h21);

        // Reset in the middle of fetching, then idle until start.
        async_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        async_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("post_rst_idle", av0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] ja;
            case ($urandom_range(0, 2))
                0: ja = 8'($urandom_range(0, 255));
                1: ja = 8'($urandom_range(0, 5));
                default: ja = 8'($urandom_range(250, 255));
            endcase
            if ($urandom_range(0, 99) < 2) begin
                async_reset();
            end else begin
                step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3,
                     $urandom_range(0, 99) < 12, ja, $urandom_range(0, 99) < 65);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
